// File: rtl/rgmii_rx_fmt.sv
// rgmii_rx_fmt: second-stage RGMII receive formatter.
// Turns per-edge nibbles from the DDR capture stage into a byte-wide GMII
// stream with preamble/SFD stripped. It also reports frame length and errors,
// guards against oversize frames and decodes the in-band link status.
module rgmii_rx_fmt #(
    parameter int LEN_W    = 16,
    parameter int MAX_LEN  = 1522,
    parameter int MAX_PRE  = 15,
    parameter int ISTAT_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             speed_1000,
    input  logic             rx_ctl_r,
    input  logic             rx_ctl_f,
    input  logic [3:0]       rxd_r,
    input  logic [3:0]       rxd_f,
    output logic             gmii_rx_dv,
    output logic             gmii_rx_er,
    output logic [7:0]       gmii_rxd,
    output logic             frame_sof,
    output logic             frame_eof,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_err,
    output logic             link_up,
    output logic [1:0]       link_speed,
    output logic             link_duplex
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        DROP     = 2'd3
    } state_t;

    // The preamble counter must be able to hold MAX_PRE + 1 to detect overrun.
    localparam int               PRE_W    = $clog2(MAX_PRE + 2);
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(MAX_PRE);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam bit               ISTAT_ON = (ISTAT_EN != 0);

    // Stage S1 input registers
    logic       ctl_r_q, ctl_f_q, speed_q;
    logic [3:0] rxd_r_q, rxd_f_q;
    logic [7:0] byte_s1;
    logic       er_s1;

    // FSM and frame context
    state_t             state_q, state_d;
    logic               mode_q, mode_d;      // 1 = byte mode, latched at frame start
    logic               mode_cur;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d, pre_cnt_base, pre_cnt_nx;
    logic               pre_ph_q, pre_ph_d, pre_ph_base, pre_ph_nx;
    logic               pre_l5_q, pre_l5_d, pre_l5_base, pre_l5_nx;
    logic               pre_sfd, pre_bad;
    logic               dat_ph_q, dat_ph_d;
    logic [3:0]         nib_lo_q, nib_lo_d;
    logic               er_lo_q, er_lo_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               er_seen_q, er_seen_d;
    logic               emit, emit_er;
    logic [7:0]         emit_byte;

    // Output registers
    logic               dv_q, dv_d, er_q, er_d, sof_q, sof_d, eof_q, eof_d, ferr_q, ferr_d;
    logic [7:0]         rxd_q, rxd_d;
    logic [LEN_W-1:0]   len_q, len_d;

    // In-band status
    logic               st_qual, st_seen_q;
    logic [3:0]         st_last_q;
    logic               link_up_q, link_dup_q;
    logic [1:0]         link_spd_q;

    assign byte_s1  = {rxd_f_q, rxd_r_q};
    assign er_s1    = ctl_r_q ^ ctl_f_q;
    assign mode_cur = (state_q == IDLE) ? speed_q : mode_q;

    // Stage S1: register every input once.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            ctl_r_q <= 1'b0;
            ctl_f_q <= 1'b0;
            speed_q <= 1'b0;
            rxd_r_q <= 4'h0;
            rxd_f_q <= 4'h0;
        end else begin
            ctl_r_q <= rx_ctl_r;
            ctl_f_q <= rx_ctl_f;
            speed_q <= speed_1000;
            rxd_r_q <= rxd_r;
            rxd_f_q <= rxd_f;
        end
    end

    // Preamble decode; the first dv cycle in IDLE is already judged as preamble.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        pre_cnt_base = (state_q == IDLE) ? '0 : pre_cnt_q;
        pre_ph_base  = (state_q == IDLE) ? 1'b0 : pre_ph_q;
        pre_l5_base  = (state_q == IDLE) ? 1'b0 : pre_l5_q;
        pre_cnt_nx   = pre_cnt_base;
        pre_ph_nx    = pre_ph_base;
        pre_l5_nx    = (rxd_r_q == 4'h5);
        pre_sfd      = 1'b0;
        pre_bad      = 1'b0;
        if (mode_cur) begin
            if (byte_s1 == 8'h55) begin
                pre_cnt_nx = pre_cnt_base + PRE_ONE;
            end else if (byte_s1 == 8'hD5) begin
                pre_sfd = 1'b1;
            end else begin
                pre_bad = 1'b1;
            end
        end else begin
            if (rxd_r_q == 4'h5) begin
                pre_ph_nx = ~pre_ph_base;
                if (pre_ph_base) begin
                    pre_cnt_nx = pre_cnt_base + PRE_ONE;
                end
            end else if (rxd_r_q == 4'hD && pre_l5_base) begin
                pre_sfd = 1'b1;
            end else begin
                pre_bad = 1'b1;
            end
        end
        if (pre_cnt_nx > PRE_MAX) begin
            pre_bad = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ctl_r_q) begin
                    if (pre_bad)      state_d = DROP;
                    else if (pre_sfd) state_d = DATA;
                    else              state_d = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (!ctl_r_q)     state_d = IDLE;
                else if (pre_bad) state_d = DROP;
                else if (pre_sfd) state_d = DATA;
            end
            DATA: begin
                if (!ctl_r_q)              state_d = IDLE;
                else if (cnt_q == LEN_MAX) state_d = DROP;
            end
            DROP: begin
                if (!ctl_r_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and frame-context next values.
    always_comb begin
        mode_d    = mode_q;
        pre_cnt_d = pre_cnt_q;
        pre_ph_d  = pre_ph_q;
        pre_l5_d  = pre_l5_q;
        dat_ph_d  = dat_ph_q;
        nib_lo_d  = nib_lo_q;
        er_lo_d   = er_lo_q;
        cnt_d     = cnt_q;
        er_seen_d = er_seen_q;
        emit      = 1'b0;
        emit_byte = 8'h00;
        emit_er   = 1'b0;
        dv_d      = 1'b0;
        er_d      = 1'b0;
        rxd_d     = 8'h00;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        len_d     = len_q;
        ferr_d    = ferr_q;
        case (state_q)
            IDLE, PREAMBLE: begin
                if (ctl_r_q) begin
                    if (state_q == IDLE) mode_d = speed_q;
                    pre_cnt_d = pre_cnt_nx;
                    pre_ph_d  = pre_ph_nx;
                    pre_l5_d  = pre_l5_nx;
                end
                // Payload context starts clean on the cycle after SFD.
                cnt_d     = '0;
                dat_ph_d  = 1'b0;
                er_seen_d = 1'b0;
            end
            DATA: begin
                if (!ctl_r_q) begin
                    eof_d  = 1'b1;
                    len_d  = cnt_q;
                    ferr_d = er_seen_q | (~mode_q & dat_ph_q);
                end else if (cnt_q == LEN_MAX) begin
                    eof_d  = 1'b1;
                    len_d  = LEN_MAX;
                    ferr_d = 1'b1;
                end else if (mode_q) begin
                    emit      = 1'b1;
                    emit_byte = byte_s1;
                    emit_er   = er_s1;
                end else if (!dat_ph_q) begin
                    nib_lo_d  = rxd_r_q;
                    er_lo_d   = er_s1;
                    dat_ph_d  = 1'b1;
                    er_seen_d = er_seen_q | er_s1;
                end else begin
                    emit      = 1'b1;
                    emit_byte = {rxd_r_q, nib_lo_q};
                    emit_er   = er_s1 | er_lo_q;
                    dat_ph_d  = 1'b0;
                end
                if (emit) begin
                    dv_d      = 1'b1;
                    rxd_d     = emit_byte;
                    er_d      = emit_er;
                    sof_d     = (cnt_q == '0);
                    cnt_d     = cnt_q + LEN_ONE;
                    er_seen_d = er_seen_q | emit_er;
                end
            end
            default: ;
        endcase
    end

    // Frame-context and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= 1'b0;
            pre_cnt_q <= '0;
            pre_ph_q  <= 1'b0;
            pre_l5_q  <= 1'b0;
            dat_ph_q  <= 1'b0;
            nib_lo_q  <= 4'h0;
            er_lo_q   <= 1'b0;
            cnt_q     <= '0;
            er_seen_q <= 1'b0;
            dv_q      <= 1'b0;
            er_q      <= 1'b0;
            rxd_q     <= 8'h00;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            len_q     <= '0;
            ferr_q    <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            pre_cnt_q <= pre_cnt_d;
            pre_ph_q  <= pre_ph_d;
            pre_l5_q  <= pre_l5_d;
            dat_ph_q  <= dat_ph_d;
            nib_lo_q  <= nib_lo_d;
            er_lo_q   <= er_lo_d;
            cnt_q     <= cnt_d;
            er_seen_q <= er_seen_d;
            dv_q      <= dv_d;
            er_q      <= er_d;
            rxd_q     <= rxd_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            len_q     <= len_d;
            ferr_q    <= ferr_d;
        end
    end

    // In-band status: idle cycles without dv or er, accepted after two equal samples.
    assign st_qual = ISTAT_ON && (state_q == IDLE) && !ctl_r_q && !ctl_f_q;

    // In-band status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_last_q  <= 4'h0;
            st_seen_q  <= 1'b0;
            link_up_q  <= 1'b0;
            link_spd_q <= 2'b00;
            link_dup_q <= 1'b0;
        end else if (st_qual) begin
            st_last_q <= rxd_r_q;
            st_seen_q <= 1'b1;
            if (st_seen_q && st_last_q == rxd_r_q && rxd_r_q[2:1] != 2'b11) begin
                link_up_q  <= rxd_r_q[0];
                link_spd_q <= rxd_r_q[2:1];
                link_dup_q <= rxd_r_q[3];
            end
        end else begin
            st_seen_q <= 1'b0;
        end
    end

    assign gmii_rx_dv  = dv_q;
    assign gmii_rx_er  = er_q;
    assign gmii_rxd    = rxd_q;
    assign frame_sof   = sof_q;
    assign frame_eof   = eof_q;
    assign frame_len   = len_q;
    assign frame_err   = ferr_q;
    assign link_up     = link_up_q;
    assign link_speed  = link_spd_q;
    assign link_duplex = link_dup_q;

endmodule
